// File: rtl/cam_capture_ctrl_if.sv
// Handshake bundle between the camera register block, the camera/MIPI side and the DMA.
// slave = the capture sequencer, master = whoever drives the controls and camera/DMA events.
interface cam_capture_ctrl_if;
   logic        cfg_mipi_rstn;
   logic        cfg_trigger;
   logic        cfg_continuous;
   logic        cfg_dma_init_done;
   logic        frame_start;
   logic        frame_end;
   logic        dma_ready;
   logic        dma_done;
   logic        mipi_rstn;
   logic        dma_start;
   logic        capture_busy;
   logic        timeout_err;
   logic [31:0] frames_per_second;
   logic [31:0] status;

   modport slave (
      input  cfg_mipi_rstn, cfg_trigger, cfg_continuous, cfg_dma_init_done,
      input  frame_start, frame_end, dma_ready, dma_done,
      output mipi_rstn, dma_start, capture_busy, timeout_err, frames_per_second, status
   );

   modport master (
      output cfg_mipi_rstn, cfg_trigger, cfg_continuous, cfg_dma_init_done,
      output frame_start, frame_end, dma_ready, dma_done,
      input  mipi_rstn, dma_start, capture_busy, timeout_err, frames_per_second, status
   );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Camera capture sequencer: timed MIPI reset release, frame-aligned DMA start pulses,
// capture watchdog, frames-per-second meter and a packed debug status word.
module cam_capture_ctrl #(
   parameter int CLK_FREQ_HZ     = 100000000,
   parameter int RST_HOLD_CYCLES = 1024,
   parameter int FRAME_TIMEOUT   = 16777216
) (
   input logic               clk,
   input logic               resetn,
   cam_capture_ctrl_if.slave bus
);
   localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam int WD_W   = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
   localparam int WIN_W  = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(FRAME_TIMEOUT - 1);
   localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(CLK_FREQ_HZ - 1);

   typedef enum logic [2:0] {
      ST_RST       = 3'd0,
      ST_WAIT_INIT = 3'd1,
      ST_IDLE      = 3'd2,
      ST_ARM       = 3'd3,
      ST_CAPTURE   = 3'd4
   } state_t;

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic              trig_q;
   logic              pending;
   logic              timeout_err;
   logic              mipi_rstn;
   logic              dma_start;
   logic [15:0]       cap_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [31:0]       frame_cnt;
   logic [31:0]       fps;

   logic trig_rise;
   logic busy;
   logic wd_fire;

   assign trig_rise = bus.cfg_trigger & ~trig_q;
   assign busy      = (state == ST_ARM) || (state == ST_CAPTURE);
   assign wd_fire   = (wd_cnt == WD_MAX);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_RST;
         hold_cnt    <= '0;
         wd_cnt      <= '0;
         trig_q      <= 1'b0;
         pending     <= 1'b0;
         timeout_err <= 1'b0;
         mipi_rstn   <= 1'b0;
         dma_start   <= 1'b0;
         cap_cnt     <= '0;
      end else begin
         trig_q    <= bus.cfg_trigger;
         dma_start <= 1'b0;
         wd_cnt    <= busy ? wd_cnt + 1'b1 : '0;
         if (trig_rise)
            timeout_err <= 1'b0;
         if (trig_rise && (state inside {ST_IDLE, ST_ARM, ST_CAPTURE}))
            pending <= 1'b1;

         if (!bus.cfg_mipi_rstn) begin
            // Abort: back to reset from anywhere, dropping any queued request.
            state       <= ST_RST;
            hold_cnt    <= '0;
            wd_cnt      <= '0;
            pending     <= 1'b0;
            timeout_err <= 1'b0;
            mipi_rstn   <= 1'b0;
         end else begin
            mipi_rstn <= (state != ST_RST);
            if ((state != ST_RST) && !bus.cfg_dma_init_done) begin
               state   <= ST_WAIT_INIT;
               wd_cnt  <= '0;
               pending <= 1'b0;
            end else begin
               case (state)
                  ST_RST: begin
                     if (hold_cnt == HOLD_MAX) begin
                        state    <= ST_WAIT_INIT;
                        hold_cnt <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
                  ST_WAIT_INIT: begin
                     if (bus.cfg_dma_init_done)
                        state <= ST_IDLE;
                  end
                  ST_IDLE: begin
                     if ((pending || bus.cfg_continuous) && bus.dma_ready)
                        state <= ST_ARM;
                  end
                  ST_ARM: begin
                     // A trigger edge landing on the clearing cycle stays queued.
                     if (bus.frame_start) begin
                        state     <= ST_CAPTURE;
                        dma_start <= 1'b1;
                        pending   <= trig_rise;
                        wd_cnt    <= '0;
                     end else if (wd_fire) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                        pending     <= trig_rise;
                        wd_cnt      <= '0;
                     end
                  end
                  ST_CAPTURE: begin
                     // dma_done beats a simultaneous watchdog expiry.
                     if (bus.dma_done) begin
                        state   <= ST_IDLE;
                        cap_cnt <= cap_cnt + 16'd1;
                        wd_cnt  <= '0;
                     end else if (wd_fire) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                        pending     <= trig_rise;
                        wd_cnt      <= '0;
                     end
                  end
                  default: state <= ST_RST;
               endcase
            end
         end
      end
   end

   // FPS window is free-running from reset, independent of the capture state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         win_cnt   <= '0;
         frame_cnt <= '0;
         fps       <= '0;
      end else if (win_cnt == WIN_MAX) begin
         win_cnt   <= '0;
         frame_cnt <= '0;
         fps       <= frame_cnt + {31'd0, bus.frame_end};
      end else begin
         win_cnt   <= win_cnt + 1'b1;
         frame_cnt <= frame_cnt + {31'd0, bus.frame_end};
      end
   end

   assign bus.mipi_rstn         = mipi_rstn;
   assign bus.dma_start         = dma_start;
   assign bus.capture_busy      = busy;
   assign bus.timeout_err       = timeout_err;
   assign bus.frames_per_second = fps;
   assign bus.status            = {cap_cnt, 11'd0, timeout_err, pending, state};
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the sequencer rules.
module tb_cam_capture_ctrl;
   localparam int CLK_HZ  = 1000;
   localparam int HOLD    = 8;
   localparam int TO      = 64;
   localparam int S_RST   = 0;
   localparam int S_WAIT  = 1;
   localparam int S_IDLE  = 2;
   localparam int S_ARM   = 3;
   localparam int S_CAP   = 4;

   logic clk;
   logic resetn;
   cam_capture_ctrl_if bus ();

   cam_capture_ctrl #(
      .CLK_FREQ_HZ    (CLK_HZ),
      .RST_HOLD_CYCLES(HOLD),
      .FRAME_TIMEOUT  (TO)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Behavioural model: state name, time spent in it, queued request, sticky error.
   int m_st, m_tis, m_run, m_cnt, m_fps, m_cyc;
   bit m_pend, m_err, m_mipi, m_dma, m_prev_trig;
   int m_fe_q[$];

   task automatic model_reset();
      m_st = S_RST; m_tis = 0; m_run = 0; m_cnt = 0; m_fps = 0; m_cyc = 0;
      m_pend = 0; m_err = 0; m_mipi = 0; m_dma = 0; m_prev_trig = 0;
      m_fe_q.delete();
   endtask

   task automatic model_step();
      bit rise, fire, pend_old;
      int nxt, hits;
      rise = bus.cfg_trigger && !m_prev_trig;
      m_prev_trig = bus.cfg_trigger;
      pend_old = m_pend;
      nxt = m_st;
      m_dma = 0;
      if (bus.frame_end) m_fe_q.push_back(m_cyc);
      if (m_cyc % CLK_HZ == CLK_HZ - 1) begin
         hits = 0;
         foreach (m_fe_q[i]) if (m_fe_q[i] / CLK_HZ == m_cyc / CLK_HZ) hits++;
         m_fps = hits;
         m_fe_q.delete();
      end
      m_cyc++;
      if (!bus.cfg_mipi_rstn) begin
         nxt = S_RST; m_pend = 0; m_err = 0; m_run = 0; m_mipi = 0;
      end else begin
         m_mipi = (m_st != S_RST);
         if (rise) m_err = 0;
         if (rise && m_st >= S_IDLE) m_pend = 1;
         if (m_st != S_RST && !bus.cfg_dma_init_done) begin
            nxt = S_WAIT; m_pend = 0;
         end else begin
            fire = (m_tis + 1 == TO);
            case (m_st)
               S_RST:  begin m_run++; if (m_run >= HOLD) nxt = S_WAIT; end
               S_WAIT: nxt = S_IDLE;
               S_IDLE: if ((pend_old || bus.cfg_continuous) && bus.dma_ready) nxt = S_ARM;
               S_ARM: begin
                  if (bus.frame_start) begin nxt = S_CAP; m_dma = 1; m_pend = rise; end
                  else if (fire) begin nxt = S_IDLE; m_err = 1; m_pend = rise; end
               end
               S_CAP: begin
                  if (bus.dma_done) begin nxt = S_IDLE; m_cnt = (m_cnt + 1) % 65536; end
                  else if (fire) begin nxt = S_IDLE; m_err = 1; m_pend = rise; end
               end
               default: nxt = S_RST;
            endcase
         end
      end
      m_tis = (nxt != m_st) ? 0 : m_tis + 1;
      m_st = nxt;
   endtask

   always @(posedge clk) begin
      if (!resetn) model_reset();
      else begin
         model_step();
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         chk("ctl", {28'd0, bus.mipi_rstn, bus.dma_start, bus.capture_busy, bus.timeout_err},
             {28'd0, m_mipi, m_dma, (m_st == S_ARM || m_st == S_CAP), m_err});
         chk("status", bus.status, (m_cnt << 16) | (int'(m_err) << 4) | (int'(m_pend) << 3) | m_st);
         chk("fps", bus.frames_per_second, m_fps);
      end
   end

   int nst, last, narm, fs_div;

   initial begin
      resetn = 0;
      bus.cfg_mipi_rstn = 0; bus.cfg_trigger = 0; bus.cfg_continuous = 0;
      bus.cfg_dma_init_done = 0; bus.frame_start = 0; bus.frame_end = 0;
      bus.dma_ready = 1; bus.dma_done = 0;
      repeat (3) tick();
      chk("rst_ctl", {28'd0, bus.mipi_rstn, bus.dma_start, bus.capture_busy, bus.timeout_err}, 0);
      chk("rst_status", bus.status, 0);
      chk("rst_fps", bus.frames_per_second, 0);
      resetn = 1;

      // Reset release, hold restart, and the first FPS window.
      for (int k = 0; k < 1000; k++) begin
         if (k == 8)   chk("rel_c8", bus.mipi_rstn, 0);
         if (k == 9)   chk("rel_c9", bus.mipi_rstn, 1);
         if (k == 21)  chk("abort_mipi", bus.mipi_rstn, 0);
         if (k == 39)  chk("restart_c8", bus.mipi_rstn, 0);
         if (k == 40)  chk("restart_c9", bus.mipi_rstn, 1);
         if (k == 999) chk("fps_pre", bus.frames_per_second, 0);
         bus.cfg_mipi_rstn = !((k >= 20 && k < 25) || k == 30);
         bus.frame_end = (k == 100 || k == 250 || k == 400 || k == 550 ||
                          k == 700 || k == 850 || k == 999);
         if (k == 100) bus.cfg_dma_init_done = 1;
         tick();
      end
      bus.frame_end = 0;
      chk("fps_win1", bus.frames_per_second, 7);

      // Single shot.
      chk("ss_idle", bus.status[2:0], S_IDLE);
      bus.cfg_trigger = 1;
      repeat (10) tick();
      chk("ss_arm", bus.status[2:0], S_ARM);
      chk("ss_no_early", bus.dma_start, 0);
      bus.frame_start = 1; tick(); bus.frame_start = 0;
      chk("ss_dma", bus.dma_start, 1);
      chk("ss_cap", bus.status[2:0], S_CAP);
      nst = 0;
      repeat (5) begin tick(); nst += int'(bus.dma_start); end
      chk("ss_once", nst, 0);
      bus.dma_done = 1; tick(); bus.dma_done = 0;
      chk("ss_count", bus.status[31:16], 1);
      chk("ss_back_idle", bus.status[2:0], S_IDLE);
      bus.cfg_trigger = 0;

      // Continuous mode, five frames.
      bus.cfg_continuous = 1;
      repeat (3) tick();
      nst = 0; last = -100;
      for (int k = 0; k < 120; k++) begin
         if (bus.dma_start) begin
            nst++; last = k;
            if (nst == 5) bus.cfg_continuous = 0;
         end
         bus.frame_start = (k % 20 == 0) && (k < 100);
         bus.dma_done = (k == last + 15);
         tick();
      end
      bus.frame_start = 0; bus.dma_done = 0;
      chk("cont_starts", nst, 5);
      chk("cont_count", bus.status[31:16], 6);
      chk("cont_idle", bus.status[2:0], S_IDLE);

      // Watchdog in ARM.
      bus.cfg_trigger = 1; tick();
      narm = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.status[2:0] == 3'(S_ARM)) narm++;
         else if (narm > 0) break;
      end
      chk("wd_arm_cycles", narm, TO);
      chk("wd_err", bus.timeout_err, 1);
      chk("wd_idle", bus.status[2:0], S_IDLE);
      bus.cfg_trigger = 0; tick();
      bus.cfg_trigger = 1; tick();
      chk("wd_err_clr", bus.timeout_err, 0);
      chk("wd_pend", bus.status[3], 1);
      tick();
      chk("wd_rearm", bus.status[2:0], S_ARM);

      // dma_done on the same cycle the watchdog expires in CAPTURE.
      bus.frame_start = 1; tick(); bus.frame_start = 0;
      chk("dt_cap", bus.status[2:0], S_CAP);
      repeat (63) tick();
      bus.dma_done = 1; tick(); bus.dma_done = 0;
      chk("dt_no_err", bus.timeout_err, 0);
      chk("dt_count", bus.status[31:16], 7);
      chk("dt_idle", bus.status[2:0], S_IDLE);

      // Abort while capturing with a request queued.
      bus.cfg_trigger = 0; tick();
      bus.cfg_trigger = 1; tick(); tick();
      chk("ab_arm", bus.status[2:0], S_ARM);
      bus.frame_start = 1; tick(); bus.frame_start = 0;
      bus.cfg_trigger = 0; tick();
      bus.cfg_trigger = 1; tick();
      chk("ab_pend_cap", bus.status[3:0], {1'b1, 3'(S_CAP)});
      bus.cfg_mipi_rstn = 0; tick();
      chk("ab_state", bus.status[2:0], S_RST);
      chk("ab_mipi", bus.mipi_rstn, 0);
      chk("ab_pend", bus.status[3], 0);
      chk("ab_no_dma", bus.dma_start, 0);
      bus.cfg_mipi_rstn = 1; bus.cfg_trigger = 0;

      while (cyc < 2000) tick();
      chk("fps_win2", bus.frames_per_second, 0);

      // Randomized traffic against the model.
      for (int r = 0; r < 3000; r++) begin
         fs_div = ((r / 500) % 2 == 1) ? 150 : 10;
         if (bus.cfg_mipi_rstn) begin
            if ($urandom % 400 == 0) bus.cfg_mipi_rstn = 0;
         end else if ($urandom % 4 == 0) bus.cfg_mipi_rstn = 1;
         if (bus.cfg_dma_init_done) begin
            if ($urandom % 250 == 0) bus.cfg_dma_init_done = 0;
         end else if ($urandom % 5 == 0) bus.cfg_dma_init_done = 1;
         if ($urandom % 15 == 0)  bus.cfg_trigger = ~bus.cfg_trigger;
         if ($urandom % 150 == 0) bus.cfg_continuous = ~bus.cfg_continuous;
         bus.dma_ready   = ($urandom % 5) != 0;
         bus.frame_start = ($urandom % fs_div) == 0;
         bus.frame_end   = ($urandom % 8) == 0;
         bus.dma_done    = ($urandom % ((fs_div == 10) ? 12 : 90)) == 0;
         tick();
      end
      bus.frame_start = 0; bus.frame_end = 0; bus.dma_done = 0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
